// File: rtl/keypad_entry_collector.sv
// rtl/keypad_entry_collector.sv - debounced one-hot keypad to packed 4-digit entry word
module keypad_entry_collector #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int CNT_W           = 10
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic [15:0] BUTTONS,
    input  logic        Lock_Busy,
    output logic [15:0] Entry_Code,
    output logic        Entry_Valid,
    output logic [2:0]  Digit_Count,
    output logic        Key_Error,
    output logic        Timeout
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t            state, next_state;
    logic [15:0]       sync1, sync, candidate, debounced, shreg;
    logic [DB_W-1:0]   stab_cnt;
    logic [CNT_W-1:0]  timer;
    logic              arm, press, stable_zero, one_hot;
    logic              accept, key_err, tmo;
    logic [3:0]        code;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            sync1     <= '0;
            sync      <= '0;
            candidate <= '0;
            stab_cnt  <= '0;
            debounced <= '0;
        end else begin
            sync1 <= BUTTONS;
            sync  <= sync1;
            if (sync != candidate) begin
                candidate <= sync;
                stab_cnt  <= '0;
            end else if (stab_cnt == DB_MAX) begin
                debounced <= candidate;
            end else begin
                stab_cnt <= stab_cnt + 1'b1;
            end
        end
    end

    // Re-arm only on a release confirmed by the debouncer, so a key held through reset stays ignored.
    assign stable_zero = (sync == candidate) && (candidate == '0) && (stab_cnt == DB_MAX) && (sync1 == '0);
    assign press       = arm && (debounced != '0);
    assign one_hot     = $onehot(debounced);

    always_ff @(posedge CLK) begin
        if (!RST)             arm <= 1'b0;
        else if (press)       arm <= 1'b0;
        else if (stable_zero) arm <= 1'b1;
    end

    always_comb begin
        code = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (debounced[i]) code = 4'(i);
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        key_err    = 1'b0;
        tmo        = 1'b0;
        if (!EN) begin
            next_state = IDLE;
        end else if (state == DONE) begin
            next_state = IDLE;
        end else if (press && !Lock_Busy) begin
            if (one_hot) begin
                accept     = 1'b1;
                next_state = (Digit_Count == 3'd3) ? DONE : COLLECT;
            end else begin
                key_err    = 1'b1;
                next_state = IDLE;
            end
        end else if (state == COLLECT && timer == TMO_MAX) begin
            tmo        = 1'b1;
            next_state = IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) state <= IDLE;
        else      state <= next_state;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            shreg       <= '0;
            Entry_Code  <= '0;
            Entry_Valid <= 1'b0;
            Digit_Count <= '0;
            Key_Error   <= 1'b0;
            Timeout     <= 1'b0;
            timer       <= '0;
        end else begin
            Entry_Valid <= 1'b0;
            Key_Error   <= key_err;
            Timeout     <= tmo;
            if (!EN) begin
                Digit_Count <= '0;
                timer       <= '0;
            end else if (state == DONE) begin
                Entry_Code  <= shreg;
                Entry_Valid <= 1'b1;
            end else if (accept) begin
                shreg[{Digit_Count[1:0], 2'b00} +: 4] <= code;
                Digit_Count <= (Digit_Count == 3'd3) ? 3'd0 : Digit_Count + 3'd1;
                timer       <= '0;
            end else if (key_err || tmo) begin
                Digit_Count <= '0;
                timer       <= '0;
            end else if (state == COLLECT) begin
                timer <= timer + 1'b1;
            end
        end
    end

endmodule
